// File: rtl/axis_escape_encoder.sv
// AXI-Stream byte-stuffing encoder: reserved beats become ESCAPE_SYMBOL + (beat ^ XOR_MASK).
// Optional statistics counters are built when ESC_STATS_EN is defined.
module axis_escape_encoder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ESCAPE_SYMBOL = 8'hE5,
    parameter int unsigned NUM_RESERVED = 1,
    parameter logic [NUM_RESERVED*DATA_WIDTH-1:0] RESERVED_SYMBOLS = 8'hD5,
    parameter logic [DATA_WIDTH-1:0] XOR_MASK = 8'h00
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef ESC_STATS_EN
    ,
    output logic [31:0]           stat_escapes,
    output logic [31:0]           stat_frames
`endif
);

    typedef enum logic [0:0] {
        ST_PASS   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    hold_last_q, hold_last_d;

    logic is_rsvd;
    logic slot_free;
    logic in_hs;

    always_comb begin
        is_rsvd = (s_axis_tdata == ESCAPE_SYMBOL);
        for (int i = 0; i < int'(NUM_RESERVED); i++) begin
            if (s_axis_tdata == RESERVED_SYMBOLS[i*DATA_WIDTH +: DATA_WIDTH]) begin
                is_rsvd = 1'b1;
            end
        end
    end

    assign slot_free     = !valid_q || m_axis_tready;
    assign s_axis_tready = !areset && (state_q == ST_PASS) && slot_free;
    assign in_hs         = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        last_d      = last_q;
        valid_d     = valid_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        unique case (state_q)
            ST_PASS: begin
                if (in_hs) begin
                    valid_d = 1'b1;
                    if (is_rsvd) begin
                        data_d      = ESCAPE_SYMBOL;
                        last_d      = 1'b0;
                        hold_data_d = s_axis_tdata ^ XOR_MASK;
                        hold_last_d = s_axis_tlast;
                        state_d     = ST_SECOND;
                    end else begin
                        data_d = s_axis_tdata;
                        last_d = s_axis_tlast;
                    end
                end else if (slot_free) begin
                    valid_d = 1'b0;
                end
            end
            ST_SECOND: begin
                // Escape beat stays valid until taken; then the held beat follows.
                if (m_axis_tready) begin
                    data_d  = hold_data_q;
                    last_d  = hold_last_q;
                    valid_d = 1'b1;
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_PASS;
            data_q      <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;

`ifdef ESC_STATS_EN
    logic [31:0] esc_cnt_q, esc_cnt_d;
    logic [31:0] frm_cnt_q, frm_cnt_d;
    logic        esc_load;
    logic        frm_done;

    assign esc_load = (state_q == ST_PASS) && in_hs && is_rsvd;
    assign frm_done = valid_q && m_axis_tready && last_q;

    always_comb begin
        esc_cnt_d = esc_cnt_q;
        frm_cnt_d = frm_cnt_q;
        if (esc_load && (esc_cnt_q != 32'hFFFF_FFFF)) begin
            esc_cnt_d = esc_cnt_q + 32'd1;
        end
        if (frm_done && (frm_cnt_q != 32'hFFFF_FFFF)) begin
            frm_cnt_d = frm_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            esc_cnt_q <= '0;
            frm_cnt_q <= '0;
        end else begin
            esc_cnt_q <= esc_cnt_d;
            frm_cnt_q <= frm_cnt_d;
        end
    end

    assign stat_escapes = esc_cnt_q;
    assign stat_frames  = frm_cnt_q;
`endif

endmodule

// File: tb/tb_axis_escape_encoder.sv
// Self-checking bench for axis_escape_encoder: directed scenarios plus a
// randomized handshake run scored against a queue-based stuffing model.
module tb_axis_escape_encoder;

    logic       aclk;
    logic       areset;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    logic [7:0] b_s_tdata;
    logic       b_s_tvalid;
    logic       b_s_tready;
    logic       b_s_tlast;
    logic [7:0] b_m_tdata;
    logic       b_m_tvalid;
    logic       b_m_tready;
    logic       b_m_tlast;

`ifdef ESC_STATS_EN
    logic [31:0] stat_escapes;
    logic [31:0] stat_frames;
    logic [31:0] b_stat_escapes;
    logic [31:0] b_stat_frames;
`endif

    int checks = 0;
    int passed = 0;

    axis_escape_encoder dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
`ifdef ESC_STATS_EN
        ,
        .stat_escapes  (stat_escapes),
        .stat_frames   (stat_frames)
`endif
    );

    axis_escape_encoder #(
        .DATA_WIDTH       (8),
        .ESCAPE_SYMBOL    (8'hE5),
        .NUM_RESERVED     (2),
        .RESERVED_SYMBOLS (16'h7ED5),
        .XOR_MASK         (8'h20)
    ) dut_b (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (b_s_tdata),
        .s_axis_tvalid (b_s_tvalid),
        .s_axis_tready (b_s_tready),
        .s_axis_tlast  (b_s_tlast),
        .m_axis_tdata  (b_m_tdata),
        .m_axis_tvalid (b_m_tvalid),
        .m_axis_tready (b_m_tready),
        .m_axis_tlast  (b_m_tlast)
`ifdef ESC_STATS_EN
        ,
        .stat_escapes  (b_stat_escapes),
        .stat_frames   (b_stat_frames)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic test_reset();
        areset     = 1'b1;
        s_tvalid   = 1'b1;
        s_tdata    = 8'h55;
        s_tlast    = 1'b1;
        m_tready   = 1'b1;
        b_s_tvalid = 1'b0;
        b_s_tdata  = 8'h00;
        b_s_tlast  = 1'b0;
        b_m_tready = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0) begin
            $display("FAIL reset_outputs: got v=%b d=%h l=%b want 0/00/0", m_tvalid, m_tdata, m_tlast);
        end else passed++;
        checks++;
        if (s_tready !== 1'b0) begin
            $display("FAIL reset_tready: got %b want 0", s_tready);
        end else passed++;
`ifdef ESC_STATS_EN
        checks++;
        if (stat_escapes !== 32'd0 || stat_frames !== 32'd0) begin
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_escapes, stat_frames);
        end else passed++;
`endif
        @(negedge aclk);
        s_tvalid = 1'b0;
        areset   = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            $display("FAIL post_reset: got rdy=%b v=%b want 1/0", s_tready, m_tvalid);
        end else passed++;
    endtask

    task automatic test_passthrough();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (i < 3) begin
                s_tvalid = 1'b1;
                s_tdata  = 8'(i + 1);
                s_tlast  = (i == 2);
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            if (i < 3) begin
                checks++;
                if (s_tready !== 1'b1) begin
                    $display("FAIL pass_tready%0d: got %b want 1", i, s_tready);
                end else passed++;
            end
            if (i > 0) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== 8'(i) || m_tlast !== (i == 3)) begin
                    $display("FAIL pass_out%0d: got v=%b d=%h l=%b want 1/%h/%b",
                             i, m_tvalid, m_tdata, m_tlast, 8'(i), (i == 3));
                end else passed++;
            end
        end
        @(negedge aclk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            $display("FAIL pass_idle: got v=%b want 0", m_tvalid);
        end else passed++;
    endtask

    task automatic test_escape_seq();
        logic [7:0] beats [4];
        logic [7:0] exp_d [6];
        logic       exp_l [6];
        logic       exp_r [6];
        int idx = 0;
        beats = '{8'h10, 8'hD5, 8'hE5, 8'h20};
        exp_d = '{8'h10, 8'hE5, 8'hD5, 8'hE5, 8'hE5, 8'h20};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        m_tready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge aclk);
            if (idx < 4) begin
                s_tvalid = 1'b1;
                s_tdata  = beats[idx];
                s_tlast  = (idx == 3);
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            if (c < 6) begin
                checks++;
                if (s_tready !== exp_r[c]) begin
                    $display("FAIL esc_tready%0d: got %b want %b", c, s_tready, exp_r[c]);
                end else passed++;
            end
            if (c > 0) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== exp_d[c-1] || m_tlast !== exp_l[c-1]) begin
                    $display("FAIL esc_out%0d: got v=%b d=%h l=%b want 1/%h/%b",
                             c, m_tvalid, m_tdata, m_tlast, exp_d[c-1], exp_l[c-1]);
                end else passed++;
            end
            if (s_tvalid && s_tready) idx++;
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
    endtask

    task automatic test_xor_mask();
        b_m_tready = 1'b1;
        @(negedge aclk);
        b_s_tvalid = 1'b1;
        b_s_tdata  = 8'h7E;
        b_s_tlast  = 1'b1;
        #1;
        checks++;
        if (b_s_tready !== 1'b1) begin
            $display("FAIL xor_tready: got %b want 1", b_s_tready);
        end else passed++;
        @(negedge aclk);
        b_s_tvalid = 1'b0;
        #1;
        checks++;
        if (b_m_tvalid !== 1'b1 || b_m_tdata !== 8'hE5 || b_m_tlast !== 1'b0) begin
            $display("FAIL xor_esc: got v=%b d=%h l=%b want 1/e5/0", b_m_tvalid, b_m_tdata, b_m_tlast);
        end else passed++;
        @(negedge aclk);
        #1;
        checks++;
        if (b_m_tvalid !== 1'b1 || b_m_tdata !== 8'h5E || b_m_tlast !== 1'b1) begin
            $display("FAIL xor_second: got v=%b d=%h l=%b want 1/5e/1", b_m_tvalid, b_m_tdata, b_m_tlast);
        end else passed++;
        b_s_tvalid = 1'b1;
        b_s_tdata  = 8'h33;
        b_s_tlast  = 1'b0;
        @(negedge aclk);
        b_s_tvalid = 1'b0;
        #1;
        checks++;
        if (b_m_tvalid !== 1'b1 || b_m_tdata !== 8'h33) begin
            $display("FAIL xor_plain: got v=%b d=%h want 1/33", b_m_tvalid, b_m_tdata);
        end else passed++;
        @(negedge aclk);
    endtask

    task automatic test_backpressure();
        m_tready = 1'b1;
        @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = 8'hD5;
        s_tlast  = 1'b1;
        for (int c = 1; c < 7; c++) begin
            @(negedge aclk);
            s_tvalid = 1'b0;
            m_tready = (c >= 4);
            #1;
            if (c <= 4) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== 8'hE5 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
                    $display("FAIL bp_hold%0d: got v=%b d=%h l=%b rdy=%b want 1/e5/0/0",
                             c, m_tvalid, m_tdata, m_tlast, s_tready);
                end else passed++;
            end else if (c == 5) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== 8'hD5 || m_tlast !== 1'b1) begin
                    $display("FAIL bp_second: got v=%b d=%h l=%b want 1/d5/1", m_tvalid, m_tdata, m_tlast);
                end else passed++;
            end else begin
                checks++;
                if (m_tvalid !== 1'b0) begin
                    $display("FAIL bp_nodup: got v=%b want 0", m_tvalid);
                end else passed++;
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_d [$];
        logic       exp_l [$];
        logic [7:0] d;
        logic [7:0] prev_d;
        logic       prev_l;
        logic       prev_stall;
        logic       pend;
        int sent;
        int cyc;
        int r;
        sent = 0;
        cyc = 0;
        pend = 1'b0;
        prev_stall = 1'b0;
        prev_d = 8'h00;
        prev_l = 1'b0;
        s_tvalid = 1'b0;
        while ((sent < 1000 || exp_d.size() > 0) && cyc < 20000) begin
            @(negedge aclk);
            cyc++;
            m_tready = ($urandom_range(0, 9) < 7);
            if (!pend) s_tvalid = 1'b0;
            if (!pend && sent < 1000 && $urandom_range(0, 9) < 7) begin
                r = $urandom_range(0, 3);
                if (r == 0) d = 8'hE5;
                else if (r == 1) d = 8'hD5;
                else d = 8'($urandom);
                s_tdata  = d;
                s_tlast  = ($urandom_range(0, 7) == 0);
                s_tvalid = 1'b1;
                pend     = 1'b1;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l) begin
                    $display("FAIL rnd_stable c%0d: got v=%b d=%h l=%b want 1/%h/%b",
                             cyc, m_tvalid, m_tdata, m_tlast, prev_d, prev_l);
                end else passed++;
            end
            if (m_tvalid === 1'b1 && m_tready) begin
                checks++;
                if (exp_d.size() == 0) begin
                    $display("FAIL rnd_extra c%0d: got d=%h want no beat", cyc, m_tdata);
                end else begin
                    if (m_tdata !== exp_d[0] || m_tlast !== exp_l[0]) begin
                        $display("FAIL rnd_beat c%0d: got d=%h l=%b want %h/%b",
                                 cyc, m_tdata, m_tlast, exp_d[0], exp_l[0]);
                    end else passed++;
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            prev_stall = (m_tvalid === 1'b1) && !m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
            if (s_tvalid && s_tready === 1'b1) begin
                if (s_tdata == 8'hE5 || s_tdata == 8'hD5) begin
                    exp_d.push_back(8'hE5);
                    exp_l.push_back(1'b0);
                    exp_d.push_back(s_tdata ^ 8'h00);
                    exp_l.push_back(s_tlast);
                end else begin
                    exp_d.push_back(s_tdata);
                    exp_l.push_back(s_tlast);
                end
                sent++;
                pend = 1'b0;
            end
        end
        checks++;
        if (sent != 1000 || exp_d.size() != 0) begin
            $display("FAIL rnd_complete: got sent=%0d left=%0d want 1000/0", sent, exp_d.size());
        end else passed++;
        @(negedge aclk);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(negedge aclk);
    endtask

`ifdef ESC_STATS_EN
    task automatic test_stats();
        logic [7:0] beats [5];
        logic       lasts [5];
        int idx = 0;
        beats = '{8'hE5, 8'h11, 8'hD5, 8'h22, 8'hD5};
        lasts = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            @(negedge aclk);
            s_tvalid = 1'b1;
            s_tdata  = beats[idx];
            s_tlast  = lasts[idx];
            #1;
            if (s_tready) idx++;
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        repeat (4) @(negedge aclk);
        #1;
        checks++;
        if (idx != 5 || stat_escapes !== 32'd3 || stat_frames !== 32'd2) begin
            $display("FAIL stats_count: got sent=%0d esc=%0d frm=%0d want 5/3/2",
                     idx, stat_escapes, stat_frames);
        end else passed++;
    endtask
`endif

    task automatic test_reset_in_second();
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = 8'hD5;
        s_tlast  = 1'b1;
        @(negedge aclk);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hE5) begin
            $display("FAIL rst2_esc: got v=%b d=%h want 1/e5", m_tvalid, m_tdata);
        end else passed++;
        areset = 1'b1;
        @(negedge aclk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || s_tready !== 1'b0) begin
            $display("FAIL rst2_clear: got v=%b d=%h rdy=%b want 0/00/0", m_tvalid, m_tdata, s_tready);
        end else passed++;
`ifdef ESC_STATS_EN
        checks++;
        if (stat_escapes !== 32'd0 || stat_frames !== 32'd0) begin
            $display("FAIL rst2_stats: got %0d/%0d want 0/0", stat_escapes, stat_frames);
        end else passed++;
`endif
        @(negedge aclk);
        areset   = 1'b0;
        m_tready = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            $display("FAIL rst2_pass: got v=%b rdy=%b want 0/1", m_tvalid, s_tready);
        end else passed++;
        @(negedge aclk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            $display("FAIL rst2_discard: got v=%b d=%h want v=0", m_tvalid, m_tdata);
        end else passed++;
    endtask

    initial begin
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        test_reset();
        test_passthrough();
        test_escape_seq();
        test_xor_mask();
        test_backpressure();
        test_random();
`ifdef ESC_STATS_EN
        test_stats();
`endif
        test_reset_in_second();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axis_escape_encoder.md
# axis_escape_encoder

Parametrised AXI-Stream byte-stuffing encoder for the Manchester serial link. Any beat matching the escape symbol or one of the configured reserved symbols is replaced by a two-beat sequence: the escape symbol, then the original beat XOR-ed with a mask. Unlike the previous generation, it holds full AXI-Stream handshake compliance under back-pressure, sustains one beat per cycle for unescaped data, supports a configurable reserved-symbol set and XOR transform, and can optionally collect statistics. It sits between the framer and the Manchester serializer.

## Interface
- DATA_WIDTH, 8, beat width in bits.
- ESCAPE_SYMBOL, 8'hE5, escape marker; always treated as reserved.
- NUM_RESERVED, 1, number of additional reserved symbols (1..8).
- RESERVED_SYMBOLS, 8'hD5, packed NUM_RESERVED*DATA_WIDTH vector; symbol i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- XOR_MASK, 8'h00, applied to the escaped beat; 0 reproduces plain escaping.
- aclk  in  1  sole clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of frame.
- m_axis_tdata  out  DATA_WIDTH  output beat (registered).
- m_axis_tvalid  out  1  output valid (registered).
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  end of frame (registered).
- stat_escapes  out  32  escapes emitted; present only with ESC_STATS_EN.
- stat_frames  out  32  frames completed on the output; present only with ESC_STATS_EN.

## Operation
- A beat is reserved when it equals ESCAPE_SYMBOL or any RESERVED_SYMBOLS entry; the compare is combinational on s_axis_tdata.
- The output stage is a single register slot: "free" means !m_axis_tvalid || m_axis_tready.
- State PASS:
  - s_axis_tready = slot free.
  - On an input handshake with a non-reserved beat: the slot loads the beat and its tlast; m_axis_tvalid=1.
  - On an input handshake with a reserved beat: the slot loads ESCAPE_SYMBOL with tlast=0; hold_data = tdata ^ XOR_MASK and hold_last = tlast are captured; next state is SECOND.
  - With no input handshake and the slot free: m_axis_tvalid <= 0.
- State SECOND:
  - s_axis_tready = 0.
  - m_axis_tvalid stays 1.
  - When m_axis_tready is high, the slot loads hold_data/hold_last and the state returns to PASS.
- tlast on a reserved beat moves to the second output beat only; the escape beat never carries tlast.
- While m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast hold stable.

## Timing
- Reset: state=PASS.
- Reset values of outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0 during reset, stats=0.
- Hold registers clear to 0 on reset.
- Latency: input handshake at cycle N gives the output beat visible at N+1.
- Throughput:
  - 1 beat/cycle for unescaped data with m_axis_tready held high.
  - A reserved beat costs 2 output cycles, with exactly one input stall cycle.
- Simultaneous output accept and new input in PASS: both occur in the same cycle, with no bubble.
- Back-to-back reserved beats: E5,x,E5,y with no gaps when downstream is always ready.
- Reset asserted in SECOND: the pending second beat is discarded, the state goes to PASS, and the output is invalid on the next cycle.

## Configuration
- ESC_STATS_EN defined:
  - stat_escapes increments when an escape beat is loaded into the slot.
  - stat_frames increments on each output handshake with m_axis_tlast=1.
  - Both counters saturate at 32'hFFFFFFFF.
  - Both clear on areset.
- ESC_STATS_EN undefined: the counters and the stat_* ports are absent; datapath behaviour is identical.

## Test plan
- Defaults, m_axis_tready=1, input 01,02,03 with tlast on 03 -> output 01,02,03 on consecutive cycles, tlast only on 03, 1-cycle latency.
- Defaults, input 10,D5,E5,20 with tlast on 20 -> output 10,E5,D5,E5,E5,20; s_axis_tready low exactly one cycle after each reserved beat.
- XOR_MASK=8'h20, NUM_RESERVED=2, RESERVED_SYMBOLS={8'h7E,8'hD5}, input 7E with tlast -> output E5 (tlast=0), 5E (tlast=1).
- Defaults, input D5 with m_axis_tready low for 3 cycles after E5 appears -> E5 held stable for 3 cycles, then D5; no beat lost or duplicated; s_axis_tready=0 throughout.
- Random valid/ready toggling over 1000 random beats -> decoded output matches input exactly; tvalid never drops without a handshake.
- ESC_STATS_EN defined, two frames containing 3 reserved beats total -> stat_escapes=3, stat_frames=2; areset asserted mid-SECOND -> counters 0, m_axis_tvalid=0 on the next cycle.
